gfx256_pixel_reader: RTL
========================

GFX256_PIXEL_READER -- requirements
Module: gfx256_pixel_reader

Interface
REQ-001 SHALL have parameter point_width, default 16, width of pixel coordinates and bitmap sizes.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports target_base_i  input  32  byte base address of the bitmap; target_size_x_i  input  point_width  bitmap width in pixels.
REQ-005 SHALL have port color_depth_i  input  2  pixel depth: 00=8bpp, 01=16bpp, 10=32bpp, 11=32bpp.
REQ-006 SHALL have ports pixel_x_i, pixel_y_i  input  point_width each  pixel coordinates.
REQ-007 SHALL have ports read_i  input  1  request strobe; ack_o  output  1  one-cycle done pulse; color_o  output  32  fetched pixel, zero-extended.
REQ-008 SHALL have port invalidate_i  input  1  clears the word cache.
REQ-009 SHALL have memory-side ports read_o  output  1  read request; read_addr_o  output  32  32-byte-aligned word address; read_dat_i  input  256  returned word; read_ack_i  input  1  data valid.

Function
REQ-010 SHALL use states IDLE, CALC1, CALC2, CHECK, WAIT, EXTRACT.
REQ-011 IDLE: on read_i=1, SHALL capture x, y, width, base and depth, then go to CALC1; read_i outside IDLE SHALL be ignored.
REQ-012 CALC1 SHALL register lin = y*width + x, 32-bit unsigned, truncated.
REQ-013 CALC2 SHALL register byte_off = lin<<0/1/2 for 8/16/32bpp, word_addr = (base + byte_off) with bits [4:0] cleared, and bit_off = (base + byte_off)[4:0]*8.
REQ-014 CHECK: if cache_valid and word_addr == cache_tag (hit), SHALL go to EXTRACT without a memory access; else SHALL drive read_addr_o=word_addr, read_o=1 and go to WAIT.
REQ-015 WAIT SHALL hold read_o and read_addr_o stable until read_ack_i=1; on that edge it SHALL store read_dat_i in the cache word, set cache_tag=word_addr and cache_valid=1, deassert read_o, and go to EXTRACT.
REQ-016 EXTRACT SHALL set color_o to cache word bits [bit_off +: N] (N=8/16/32), zero-extended to 32; it SHALL pulse ack_o for exactly one cycle and return to IDLE.
REQ-017 Hit latency: ack_o SHALL be high in the cycle after the 5th rising edge, counting the edge that samples read_i as the 1st.
REQ-018 Miss: read_o SHALL rise after the 4th edge; ack_o SHALL be high in the cycle after the edge following the read_ack_i edge.
REQ-019 color_o SHALL hold its value until the next EXTRACT.
REQ-020 read_ack_i outside WAIT SHALL be ignored.
REQ-021 invalidate_i=1 SHALL clear cache_valid in any state. If invalidate_i and read_ack_i coincide in WAIT, the data SHALL still be used for the current EXTRACT, but cache_valid SHALL end at 0.
REQ-022 Unaligned pixels SHALL NOT occur: 16bpp pixels are 2-byte aligned and 32bpp pixels are 4-byte aligned, given an aligned base. A 32bpp pixel at bit_off 224 SHALL read bits [255:224].
REQ-023 No bounds check SHALL be performed; out-of-range coordinates read wherever the computed address points.

Reset
REQ-024 rst_ni=0 SHALL immediately force state=IDLE, read_o=0, ack_o=0, read_addr_o=0, color_o=0, cache_valid=0, cache_tag=0; the cache word content is don't-care.
REQ-025 Reset during WAIT SHALL abandon the request; a read_ack_i arriving after reset release SHALL be ignored.

Verification
REQ-026 Miss, 8bpp: base=0x1000, width=640, x=3, y=1 -> read_addr_o=0x1280, read_o high after edge 4; read_ack_i with byte 3 of the word = 0xA5 -> color_o=0x000000A5, one ack_o pulse.
REQ-027 Hit: the same request repeated -> read_o stays 0; ack_o high after edge 5 with the same color_o.
REQ-028 32bpp, base=0, width=8, x=7, y=0 -> read_addr_o=0x0, bit_off=224; color_o = read_dat_i[255:224].
REQ-029 invalidate_i pulsed between two identical requests -> the second request issues read_o (miss); invalidate_i on the read_ack_i edge -> the next identical request misses.
REQ-030 rst_ni low for 1 cycle while in WAIT -> read_o=0 and ack_o=0 at once; a late read_ack_i produces no ack_o.
REQ-031 read_i held high continuously -> back-to-back transactions, one per return to IDLE; read_ack_i delayed 10 cycles -> read_o and read_addr_o stable throughout.

Source files
------------

// File: rtl/gfx256_pixel_reader.sv
// gfx256_pixel_reader: fetches one 8/16/32bpp pixel from a bitmap
// through a single 256-bit word cache in front of a memory port.
module gfx256_pixel_reader #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [31:0]            target_base_i,
  input  logic [point_width-1:0] target_size_x_i,
  input  logic [1:0]             color_depth_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic                   read_i,
  output logic                   ack_o,
  output logic [31:0]            color_o,
  input  logic                   invalidate_i,
  output logic                   read_o,
  output logic [31:0]            read_addr_o,
  input  logic [255:0]           read_dat_i,
  input  logic                   read_ack_i
);

  typedef enum logic [2:0] {
    IDLE,
    CALC1,
    CALC2,
    CHECK,
    WAIT,
    EXTRACT
  } state_e;

  state_e state_q, state_d;

  logic [point_width-1:0] x_q, x_d;
  logic [point_width-1:0] y_q, y_d;
  logic [point_width-1:0] w_q, w_d;
  logic [31:0]            base_q, base_d;
  logic [1:0]             depth_q, depth_d;

  logic [31:0] lin_q, lin_d;
  logic [31:0] word_addr_q, word_addr_d;
  logic [7:0]  bit_off_q, bit_off_d;

  logic [31:0]  tag_q, tag_d;
  logic         valid_q, valid_d;
  logic [255:0] cache_q;
  logic         cache_we;

  logic        rd_q, rd_d;
  logic [31:0] raddr_q, raddr_d;
  logic        ack_q, ack_d;
  logic [31:0] color_q, color_d;

  logic [1:0]  shamt;
  logic [31:0] byte_off;
  logic [31:0] addr_sum;
  logic [31:0] win;
  logic [31:0] pix;
  logic        hit;

  // Bytes per pixel as a shift; 11 is treated as 32bpp.
  always_comb begin
    unique case (depth_q)
      2'b00:   shamt = 2'd0;
      2'b01:   shamt = 2'd1;
      default: shamt = 2'd2;
    endcase
  end

  // Address split into the aligned word and the bit position inside it.
  always_comb begin
    byte_off = lin_q << shamt;
    addr_sum = base_q + byte_off;
  end

  // Pixel select from the cached word, zero-extended to 32 bits.
  always_comb begin
    win = 32'(cache_q >> bit_off_q);
    unique case (depth_q)
      2'b00:   pix = {24'd0, win[7:0]};
      2'b01:   pix = {16'd0, win[15:0]};
      default: pix = win;
    endcase
  end

  assign hit = valid_q && (word_addr_q == tag_q);

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    base_d      = base_q;
    depth_d     = depth_q;
    lin_d       = lin_q;
    word_addr_d = word_addr_q;
    bit_off_d   = bit_off_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    cache_we    = 1'b0;
    rd_d        = rd_q;
    raddr_d     = raddr_q;
    ack_d       = 1'b0;
    color_d     = color_q;

    unique case (state_q)
      IDLE: begin
        if (read_i) begin
          x_d     = pixel_x_i;
          y_d     = pixel_y_i;
          w_d     = target_size_x_i;
          base_d  = target_base_i;
          depth_d = color_depth_i;
          state_d = CALC1;
        end
      end
      CALC1: begin
        lin_d   = 32'(y_q) * 32'(w_q) + 32'(x_q);
        state_d = CALC2;
      end
      CALC2: begin
        word_addr_d = {addr_sum[31:5], 5'd0};
        bit_off_d   = {addr_sum[4:0], 3'd0};
        state_d     = CHECK;
      end
      CHECK: begin
        if (hit) begin
          state_d = EXTRACT;
        end else begin
          rd_d    = 1'b1;
          raddr_d = word_addr_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (read_ack_i) begin
          cache_we = 1'b1;
          tag_d    = word_addr_q;
          valid_d  = 1'b1;
          rd_d     = 1'b0;
          state_d  = EXTRACT;
        end
      end
      EXTRACT: begin
        color_d = pix;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Invalidate wins over a fill landing in the same cycle.
    if (invalidate_i) valid_d = 1'b0;
  end

  // State and control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      base_q      <= '0;
      depth_q     <= '0;
      lin_q       <= '0;
      word_addr_q <= '0;
      bit_off_q   <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      rd_q        <= 1'b0;
      raddr_q     <= '0;
      ack_q       <= 1'b0;
      color_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      base_q      <= base_d;
      depth_q     <= depth_d;
      lin_q       <= lin_d;
      word_addr_q <= word_addr_d;
      bit_off_q   <= bit_off_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      raddr_q     <= raddr_d;
      ack_q       <= ack_d;
      color_q     <= color_d;
    end
  end

  // Cache word needs no reset; the valid bit guards it.
  always_ff @(posedge clk_i) begin
    if (cache_we) cache_q <= read_dat_i;
  end

  assign read_o      = rd_q;
  assign read_addr_o = raddr_q;
  assign ack_o       = ack_q;
  assign color_o     = color_q;

endmodule
